// File: rtl/vga_timing_gen.sv
// VGA raster timing generator: pixel-enable divider, raster counters with window flag,
// and a one-pixel pin-alignment stage for sync and colour, plus a per-frame tick.
module vga_timing_gen #(
    parameter int DIV     = 4,
    parameter int H_TOTAL = 800,
    parameter int H_SYNC  = 96,
    parameter int H_START = 144,
    parameter int H_END   = 784,
    parameter int V_TOTAL = 525,
    parameter int V_SYNC  = 2,
    parameter int V_START = 35,
    parameter int V_END   = 515
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [11:0] rgb_in,
    output logic [9:0]  hCount,
    output logic [9:0]  vCount,
    output logic        bright,
    output logic        hSync,
    output logic        vSync,
    output logic [11:0] vga_rgb,
    output logic        frame_tick
);

    localparam int              DW       = (DIV > 2) ? $clog2(DIV) : 1;
    localparam logic [DW-1:0]   DIV_LAST = DW'(DIV - 1);
    localparam logic [9:0]      H_LAST   = 10'(H_TOTAL - 1);
    localparam logic [9:0]      V_LAST   = 10'(V_TOTAL - 1);
    localparam logic [9:0]      H_SYNC_W = 10'(H_SYNC);
    localparam logic [9:0]      V_SYNC_W = 10'(V_SYNC);
    localparam logic [9:0]      H_ST     = 10'(H_START);
    localparam logic [9:0]      H_EN     = 10'(H_END);
    localparam logic [9:0]      V_ST     = 10'(V_START);
    localparam logic [9:0]      V_EN     = 10'(V_END);

    logic [DW-1:0] div_r;
    logic [9:0]    h_count_r;
    logic [9:0]    v_count_r;
    logic          bright_r;
    logic          hsync_r;
    logic          vsync_r;
    logic [11:0]   rgb_r;
    logic          frame_tick_r;

    logic          pix_en_s;
    logic          h_last_s;
    logic          v_last_s;
    logic [9:0]    h_next_s;
    logic [9:0]    v_next_s;
    logic          bright_next_s;

    function automatic logic in_window(input logic [9:0] h, input logic [9:0] v);
        return (h >= H_ST) && (h < H_EN) && (v >= V_ST) && (v < V_EN);
    endfunction

    // Pixel strobe and next raster position; bright is derived from the next position
    // so it lands on the same edge as the counters it describes.
    always_comb begin
        pix_en_s      = (div_r == DIV_LAST);
        h_last_s      = (h_count_r == H_LAST);
        v_last_s      = (v_count_r == V_LAST);
        h_next_s      = h_count_r;
        v_next_s      = v_count_r;
        bright_next_s = 1'b0;
        if (h_last_s) begin
            h_next_s = 10'd0;
            if (v_last_s) begin
                v_next_s = 10'd0;
            end else begin
                v_next_s = v_count_r + 10'd1;
            end
        end else begin
            h_next_s = h_count_r + 10'd1;
            v_next_s = v_count_r;
        end
        bright_next_s = in_window(h_next_s, v_next_s);
    end

    // Board-clock divider producing one pixel strobe every DIV clocks.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            div_r <= '0;
        end else if (pix_en_s) begin
            div_r <= '0;
        end else begin
            div_r <= div_r + DW'(1);
        end
    end

    // Stage 1: raster counters and active-window flag.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            h_count_r <= 10'd0;
            v_count_r <= 10'd0;
            bright_r  <= 1'b0;
        end else if (pix_en_s) begin
            h_count_r <= h_next_s;
            v_count_r <= v_next_s;
            bright_r  <= bright_next_s;
        end
    end

    // Stage 2: pins re-timed from pre-edge stage-1 values; colour blanked outside the window.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            hsync_r <= 1'b1;
            vsync_r <= 1'b1;
            rgb_r   <= 12'h000;
        end else if (pix_en_s) begin
            hsync_r <= (h_count_r >= H_SYNC_W);
            vsync_r <= (v_count_r >= V_SYNC_W);
            rgb_r   <= bright_r ? rgb_in : 12'h000;
        end
    end

    // One-clock pulse on the edge where both counters wrap to zero.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            frame_tick_r <= 1'b0;
        end else begin
            frame_tick_r <= pix_en_s && h_last_s && v_last_s;
        end
    end

    assign hCount     = h_count_r;
    assign vCount     = v_count_r;
    assign bright     = bright_r;
    assign hSync      = hsync_r;
    assign vSync      = vsync_r;
    assign vga_rgb    = rgb_r;
    assign frame_tick = frame_tick_r;

endmodule
